neuron_mac_accumulator: RTL and testbench
=========================================

// Module: neuron_mac_accumulator
// PURPOSE
//  Serial multiply-accumulate neuron stage. Consumes one (x, w) pair per accepted cycle and adds a bias.
//  Rescales the Q4.4 result, saturates it to 8 bits and presents it as z_value.
//  Sits directly upstream of the layer's activation LUT/interpolator stage, which reads
//  z_value[7:4] as the LUT address and z_value[3:0] as the interpolation fraction.
// PARAMETERS
//  N_INPUTS   4   pairs per neuron evaluation (>=2)
//  DATA_W     8   width of x, w, bias, z_value (signed two's complement)
//  FRAC_BITS  4   fractional bits of every DATA_W operand (Q4.4 at defaults)
// PORTS
//  clk        in   1          rising-edge clock
//  rst        in   1          synchronous, active-high reset
//  in_valid   in   1          x/w pair valid
//  in_ready   out  1          stage accepts a pair this cycle
//  x_in       in   DATA_W     signed activation from previous layer
//  w_in       in   DATA_W     signed weight
//  bias_in    in   DATA_W     signed bias, sampled with the first pair of each evaluation
//  out_valid  out  1          z_value holds a finished result
//  out_ready  in   1          downstream accepts z_value
//  z_value    out  DATA_W     saturated signed pre-activation, Q(DATA_W-FRAC_BITS).FRAC_BITS
// BEHAVIOUR
//  Reset: state=ACCUM, count=0, acc=0, in_ready=1, out_valid=0, z_value=0.
//  States:
//   - ACCUM: in_ready=1. A pair is accepted when in_valid&in_ready.
//   - OUT: in_ready=0, out_valid=1, z_value stable.
//  Accumulator:
//   - Width ACC_W = 2*DATA_W + clog2(N_INPUTS) + 1; never overflows internally.
//   - Products are signed full-width (2*DATA_W), Q.2*FRAC_BITS.
//  Accept with count==0: acc <= sext(bias_in)<<<FRAC_BITS + x*w.
//  Accept with 0<count<N_INPUTS-1: acc <= acc + x*w.
//  Accept with count==N_INPUTS-1 (final pair):
//   - sum = acc + x*w; r = sum >>> FRAC_BITS (arithmetic shift, floor toward -inf).
//   - z_value <= sat(r) to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
//   - count <= 0; state <= OUT; out_valid=1 the next cycle.
//  Latency: z_value valid 1 cycle after the final pair is accepted.
//  Throughput: N_INPUTS+1 cycles minimum per evaluation; one-cycle bubble in OUT.
//  OUT -> ACCUM when out_ready=1; out_valid drops the following cycle.
//  Backpressure: while out_ready=0, z_value/out_valid hold indefinitely and no pair is accepted.
//  in_valid=0 in ACCUM: acc and count hold; gaps between pairs are allowed.
//  bias_in is ignored except on the count==0 accept.
//  rst in any state or mid-evaluation discards partial acc; the next evaluation starts clean.
//  x_in/w_in/bias_in need only be stable in the accepting cycle.
// TESTING (N_INPUTS=4, DATA_W=8, FRAC_BITS=4)
//  T1 unity:
//   - stimulus: 4 pairs x=16, w=16 (1.0*1.0), bias=0.
//   - response: z_value=64 (4.0) one cycle after the 4th accept, out_valid=1.
//  T2 saturation:
//   - stimulus A: 4 pairs x=127, w=127, bias=127 -> z_value=127.
//   - stimulus B: 4 pairs x=-128, w=127, bias=0 -> z_value=-128.
//  T3 rounding:
//   - stimulus A: 4 pairs x=1, w=1, bias=0 -> z_value=0.
//   - stimulus B: 4 pairs x=-1, w=1, bias=0 -> z_value=-1 (floor).
//  T4 bias sampling:
//   - stimulus: bias_in=16 on the first pair, bias_in=-100 on pairs 2-4, all x=0.
//   - response: z_value=16.
//  T5 handshake:
//   - stimulus: random in_valid gaps; out_ready low 5 cycles then high.
//   - response: z_value stable and in_ready=0 while held; in_ready=1 the cycle after out_ready.
//   - response: back-to-back vectors give correct independent results.
//  T6 reset mid-evaluation:
//   - stimulus: accept 2 pairs of x=w=127, pulse rst, then send T1 stimulus.
//   - response: out_valid=0 after rst; z_value=64 on the next result.

Source files
------------

// File: rtl/neuron_mac_accumulator.sv
// neuron_mac_accumulator: serial Q-format MAC with bias, rescale and saturation to DATA_W
module neuron_mac_accumulator #(
  parameter int N_INPUTS  = 4,
  parameter int DATA_W    = 8,
  parameter int FRAC_BITS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] x_in,
  input  logic signed [DATA_W-1:0] w_in,
  input  logic signed [DATA_W-1:0] bias_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] z_value
);
  localparam int CNT_W = $clog2(N_INPUTS);
  localparam int ACC_W = 2 * DATA_W + $clog2(N_INPUTS) + 1;
  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] OUT   = 1'b1;
  localparam logic signed [ACC_W-1:0] Z_MAX = ACC_W'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [ACC_W-1:0] Z_MIN = ~Z_MAX;
  logic [0:0] state;
  logic [CNT_W-1:0] count;
  logic signed [ACC_W-1:0] acc, bias_term, prod_ext, sum, r;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [DATA_W-1:0] z_sat;
  logic last;
  assign prod      = x_in * w_in;
  assign prod_ext  = {{(ACC_W - 2 * DATA_W){prod[2*DATA_W-1]}}, prod};
  assign bias_term = {{(ACC_W - DATA_W){bias_in[DATA_W-1]}}, bias_in} <<< FRAC_BITS;
  assign sum       = (count == '0 ? bias_term : acc) + prod_ext;
  assign r         = sum >>> FRAC_BITS;
  assign z_sat     = r > Z_MAX ? Z_MAX[DATA_W-1:0] : r < Z_MIN ? Z_MIN[DATA_W-1:0] : r[DATA_W-1:0];
  assign last      = count == CNT_W'(N_INPUTS - 1);
  assign in_ready  = state == ACCUM;
  assign out_valid = state == OUT;
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ACCUM;
      count   <= '0;
      acc     <= '0;
      z_value <= '0;
    end else if (state == OUT) begin
      if (out_ready) state <= ACCUM;
    end else if (in_valid) begin
      if (last) begin
        z_value <= z_sat;
        count   <= '0;
        state   <= OUT;
      end else begin
        acc   <= sum;
        count <= count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_neuron_mac_accumulator.sv
// tb_neuron_mac_accumulator: table vectors, handshake/reset sequences and random evals vs a model
module tb_neuron_mac_accumulator;
  logic clk = 1'b0;
  logic rst, in_valid, out_ready;
  logic in_ready, out_valid;
  logic signed [7:0] x_in, w_in, bias_in, z_value;
  int n_cmp = 0;
  int n_bad = 0;
  int cx[4], cw[4], cb[4];
  typedef struct {
    string name;
    int x;
    int w;
    int b_first;
    int b_rest;
    int exp;
  } vec_t;
  vec_t tbl[8];
  neuron_mac_accumulator #(.N_INPUTS(4), .DATA_W(8), .FRAC_BITS(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .w_in(w_in), .bias_in(bias_in),
    .out_valid(out_valid), .out_ready(out_ready), .z_value(z_value)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic int model();
    int s, q;
    s = cb[0] * 16;
    for (int i = 0; i < 4; i++) s += cx[i] * cw[i];
    q = s / 16;
    if (s < 0 && s % 16 != 0) q -= 1;
    return q > 127 ? 127 : q < -128 ? -128 : q;
  endfunction
  task automatic send_pairs(input string name, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          x_in = 8'($urandom);
          w_in = 8'($urandom);
          bias_in = 8'($urandom);
          @(negedge clk);
        end
      end
      in_valid = 1'b1;
      x_in = 8'(cx[i]);
      w_in = 8'(cw[i]);
      bias_in = 8'(cb[i]);
      chk({name, "_in_ready"}, int'(in_ready), 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask
  task automatic take_result(input string name, input int exp, input int hold);
    int k = 0;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_out_valid"}, int'(out_valid), 1);
    chk({name, "_z"}, int'(z_value), exp);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      x_in = 8'($urandom);
      w_in = 8'($urandom);
      bias_in = 8'($urandom);
      @(negedge clk);
      chk({name, "_hold_z"}, int'(z_value), exp);
      chk({name, "_hold_in_ready"}, int'(in_ready), 0);
      chk({name, "_hold_out_valid"}, int'(out_valid), 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, "_release_in_ready"}, int'(in_ready), 1);
    chk({name, "_release_out_valid"}, int'(out_valid), 0);
  endtask
  initial begin
    tbl[0] = '{"t1_unity",    16,   16,   0,    0,   64};
    tbl[1] = '{"t2_sat_pos",  127,  127,  127,  127, 127};
    tbl[2] = '{"t2_sat_neg",  -128, 127,  0,    0,   -128};
    tbl[3] = '{"t3_round_p",  1,    1,    0,    0,   0};
    tbl[4] = '{"t3_round_n",  -1,   1,    0,    0,   -1};
    tbl[5] = '{"t4_bias",     0,    0,    16,   -100, 16};
    tbl[6] = '{"neg_bias",    -16,  16,   -16,  50,  -80};
    tbl[7] = '{"mixed",       32,   -8,   8,    -8,  -56};
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    x_in = '0;
    w_in = '0;
    bias_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_z", int'(z_value), 0);
    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < 4; i++) begin
        cx[i] = tbl[v].x;
        cw[i] = tbl[v].w;
        cb[i] = i == 0 ? tbl[v].b_first : tbl[v].b_rest;
      end
      send_pairs(tbl[v].name, 4, 1'b0);
      take_result(tbl[v].name, tbl[v].exp, 0);
    end
    for (int i = 0; i < 4; i++) begin
      cx[i] = 16;
      cw[i] = 16;
      cb[i] = 0;
    end
    send_pairs("t5_hold", 4, 1'b1);
    take_result("t5_hold", 64, 5);
    for (int i = 0; i < 4; i++) begin
      cx[i] = 127;
      cw[i] = 127;
      cb[i] = 0;
    end
    send_pairs("t6_partial", 2, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_rst_out_valid", int'(out_valid), 0);
    chk("t6_rst_in_ready", int'(in_ready), 1);
    for (int i = 0; i < 4; i++) begin
      cx[i] = 16;
      cw[i] = 16;
    end
    send_pairs("t6_after", 4, 1'b0);
    take_result("t6_after", 64, 0);
    send_pairs("t6_out_rst", 4, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_out_rst_out_valid", int'(out_valid), 0);
    chk("t6_out_rst_z", int'(z_value), 0);
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 4; i++) begin
        cx[i] = int'($signed(8'($urandom)));
        cw[i] = int'($signed(8'($urandom)));
        cb[i] = int'($signed(8'($urandom)));
      end
      send_pairs("rand", 4, 1'b1);
      take_result("rand", model(), $urandom_range(0, 3));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
